// File: rtl/i2c_slave_regs.sv
// i2c_slave_regs: wb_clk-domain I2C responder exposing a byte-addressed register file,
// with a synchronous host port to preload and inspect the registers.
// Optional write-complete interrupt (irq_o / irq_clr_i) exists only when I2C_SLAVE_WRIRQ_EN is defined.
module i2c_slave_regs #(
   parameter logic [6:0]  SLAVE_ADDR = 7'h50,
   parameter int unsigned ADDR_WIDTH = 8,
   parameter int unsigned FILTER_LEN = 3
) (
   input  logic                  wb_clk_i,
   input  logic                  wb_rst_i,
   input  logic                  scl_pad_i,
   input  logic                  sda_pad_i,
   output logic                  sda_pad_o,
   output logic                  sda_padoen_o,
   input  logic                  host_we_i,
   input  logic [ADDR_WIDTH-1:0] host_adr_i,
   input  logic [7:0]            host_dat_i,
   output logic [7:0]            host_dat_o,
`ifdef I2C_SLAVE_WRIRQ_EN
   output logic                  irq_o,
   input  logic                  irq_clr_i,
`endif
   output logic                  busy_o
);

   localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
   localparam int unsigned CNT_W = $clog2(FILTER_LEN + 1);

   typedef enum logic [3:0] {
      IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE
   } state_t;

   state_t                state;
   logic [1:0]            scl_sync, sda_sync;
   logic [CNT_W-1:0]      scl_cnt, sda_cnt;
   logic                  scl_f, sda_f, scl_d, sda_d;
   logic [7:0]            shreg;
   logic [3:0]            bit_cnt;
   logic [ADDR_WIDTH-1:0] ptr;
   logic                  rw_q;
   logic                  ack_q;
   logic [7:0]            mem [DEPTH];

   logic scl_rise_c, scl_fall_c, start_c, stop_c, i2c_we_c;
   logic [7:0] i2c_dat_c;

   // Open-drain: only the enable toggles.
   assign sda_pad_o = 1'b0;

   // Synchronise pads, filter glitches shorter than FILTER_LEN, keep previous filtered value for edges.
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         scl_sync <= 2'b11;
         sda_sync <= 2'b11;
         scl_cnt  <= '0;
         sda_cnt  <= '0;
         scl_f    <= 1'b1;
         sda_f    <= 1'b1;
         scl_d    <= 1'b1;
         sda_d    <= 1'b1;
      end else begin
         scl_sync <= {scl_sync[0], scl_pad_i};
         sda_sync <= {sda_sync[0], sda_pad_i};
         scl_d    <= scl_f;
         sda_d    <= sda_f;
         if (scl_sync[1] == scl_f) begin
            scl_cnt <= '0;
         end else if (scl_cnt == CNT_W'(FILTER_LEN - 1)) begin
            scl_f   <= scl_sync[1];
            scl_cnt <= '0;
         end else begin
            scl_cnt <= scl_cnt + CNT_W'(1);
         end
         if (sda_sync[1] == sda_f) begin
            sda_cnt <= '0;
         end else if (sda_cnt == CNT_W'(FILTER_LEN - 1)) begin
            sda_f   <= sda_sync[1];
            sda_cnt <= '0;
         end else begin
            sda_cnt <= sda_cnt + CNT_W'(1);
         end
      end
   end

   assign scl_rise_c = scl_f & ~scl_d;
   assign scl_fall_c = ~scl_f & scl_d;
   assign start_c    = scl_f & scl_d & sda_d & ~sda_f;
   assign stop_c     = scl_f & scl_d & ~sda_d & sda_f;
   assign i2c_we_c   = (state == WDATA) && scl_rise_c && (bit_cnt == 4'd7);
   assign i2c_dat_c  = {shreg[6:0], sda_f};

   // Register file: I2C write is applied last so it wins a same-address collision.
   always_ff @(posedge wb_clk_i) begin
      if (host_we_i) mem[host_adr_i] <= host_dat_i;
      if (i2c_we_c)  mem[ptr]        <= i2c_dat_c;
   end

   // Registered host read port.
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) host_dat_o <= 8'h00;
      else          host_dat_o <= mem[host_adr_i];
   end

   // Protocol FSM: sample on filtered SCL rise, change SDA drive after filtered SCL fall.
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         state        <= IDLE;
         sda_padoen_o <= 1'b1;
         busy_o       <= 1'b0;
         ptr          <= '0;
         shreg        <= 8'h00;
         bit_cnt      <= 4'd0;
         rw_q         <= 1'b0;
         ack_q        <= 1'b1;
      end else if (stop_c) begin
         state        <= IDLE;
         sda_padoen_o <= 1'b1;
         busy_o       <= 1'b0;
      end else if (start_c) begin
         state        <= ADDR;
         sda_padoen_o <= 1'b1;
         busy_o       <= 1'b0;
         bit_cnt      <= 4'd0;
      end else begin
         case (state)
            ADDR, PTR, WDATA: begin
               if (scl_rise_c) begin
                  shreg   <= {shreg[6:0], sda_f};
                  bit_cnt <= bit_cnt + 4'd1;
                  if (state == WDATA && bit_cnt == 4'd7) ptr <= ptr + ADDR_WIDTH'(1);
               end else if (scl_fall_c && bit_cnt == 4'd8) begin
                  bit_cnt <= 4'd0;
                  if (state == ADDR) begin
                     if (shreg[7:1] == SLAVE_ADDR) begin
                        sda_padoen_o <= 1'b0;
                        busy_o       <= 1'b1;
                        rw_q         <= shreg[0];
                        state        <= ADDR_ACK;
                     end else begin
                        state <= IGNORE;
                     end
                  end else if (state == PTR) begin
                     ptr          <= ADDR_WIDTH'(shreg);
                     sda_padoen_o <= 1'b0;
                     state        <= PTR_ACK;
                  end else begin
                     sda_padoen_o <= 1'b0;
                     state        <= WDATA_ACK;
                  end
               end
            end
            ADDR_ACK: begin
               if (scl_fall_c) begin
                  if (rw_q) begin
                     shreg        <= mem[ptr];
                     sda_padoen_o <= mem[ptr][7];
                     state        <= RDATA;
                  end else begin
                     sda_padoen_o <= 1'b1;
                     state        <= PTR;
                  end
               end
            end
            PTR_ACK, WDATA_ACK: begin
               if (scl_fall_c) begin
                  sda_padoen_o <= 1'b1;
                  state        <= WDATA;
               end
            end
            RDATA: begin
               if (scl_rise_c) begin
                  bit_cnt <= bit_cnt + 4'd1;
               end else if (scl_fall_c) begin
                  if (bit_cnt == 4'd8) begin
                     bit_cnt      <= 4'd0;
                     sda_padoen_o <= 1'b1;
                     state        <= RDATA_ACK;
                  end else if (bit_cnt != 4'd0) begin
                     shreg        <= {shreg[6:0], 1'b0};
                     sda_padoen_o <= shreg[6];
                  end
               end
            end
            RDATA_ACK: begin
               if (scl_rise_c) begin
                  ack_q <= sda_f;
                  ptr   <= ptr + ADDR_WIDTH'(1);
               end else if (scl_fall_c) begin
                  if (!ack_q) begin
                     shreg        <= mem[ptr];
                     sda_padoen_o <= mem[ptr][7];
                     state        <= RDATA;
                  end else begin
                     sda_padoen_o <= 1'b1;
                     state        <= IGNORE;
                  end
               end
            end
            default: ;
         endcase
      end
   end

`ifdef I2C_SLAVE_WRIRQ_EN
   logic wrote_q;

   // Flag a STOP that closes a transaction containing at least one written data byte.
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         wrote_q <= 1'b0;
         irq_o   <= 1'b0;
      end else begin
         if (stop_c)        wrote_q <= 1'b0;
         else if (i2c_we_c) wrote_q <= 1'b1;
         if (stop_c && wrote_q) irq_o <= 1'b1;
         else if (irq_clr_i)    irq_o <= 1'b0;
      end
   end
`endif

endmodule
